mic3_sample_conditioner: RTL
============================

// Module: mic3_sample_conditioner
// PURPOSE
//  Consumes 12-bit PmodMIC3 samples, already captured and resynchronised into the sysclk domain.
//  Converts offset-binary samples to signed 16-bit PCM and buffers them in a small FIFO with
//  a valid/ready output for downstream DSP/ILA. In parallel it tracks peak magnitude per window
//  and raises a sticky clip flag.
//  Sits between the SPI capture/CDC stage and any audio consumer.
// PARAMETERS
//  FIFO_DEPTH  8     PCM FIFO entries; power of 2, >=2
//  WINDOW      1024  samples per peak-measurement window; power of 2, >=2
// PORTS
//  sysclk        in   1   100 MHz system clock
//  sysrst_n      in   1   asynchronous reset, active-low
//  sample_valid  in   1   one-cycle strobe, one new sample per strobe; back-to-back strobes allowed
//  sample_raw    in   12  offset-binary mic sample (2048 = silence)
//  pcm_valid     out  1   FIFO head valid
//  pcm_ready     in   1   consumer accepts head when pcm_valid & pcm_ready
//  pcm_data      out  16  signed PCM, left-justified: {raw-2048, 4'b0}
//  drop_count    out  8   samples lost to FIFO full; saturates at 255
//  peak_valid    out  1   one-cycle pulse at end of each window
//  peak_value    out  12  max |raw-2048| over the last completed window (0..2048)
//  clip          out  1   sticky: a sample equal to 12'h000 or 12'hFFF was seen
//  clip_clr      in   1   clears clip
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; window count and running peak are 0.
//   Async assert takes effect immediately mid-operation; deassert is synchronous to sysclk.
//  Conversion: s = {~raw[11], raw[10:0]} (12-bit two's complement). Register it at the edge
//   that samples sample_valid (stage S1, with s1_valid).
//  FIFO write: at the next edge if s1_valid. pcm_valid rises 2 edges after the strobe when
//   the FIFO is empty. pcm_data holds the head entry and is registered, not a comb read.
//  Pop: on pcm_valid & pcm_ready. pcm_data/pcm_valid never change while pcm_valid & !pcm_ready.
//  Full: a write is accepted if not full, or if full and a pop occurs in the same cycle.
//   Otherwise the sample is dropped and drop_count increments, saturating at 8'hFF.
//   Simultaneous push and pop when empty: pcm_valid is not set this cycle; the data appears
//   at the next edge. Occupancy counts 0..FIFO_DEPTH with no wrap ambiguity.
//  Peak: mag = s[11] ? -s : s, 12-bit unsigned (-2048 gives 2048). It is computed in S1 for
//   every strobe, including dropped samples.
//   The window counter (log2 WINDOW bits) increments per S1 sample and wraps at WINDOW.
//   On the S1 sample with count == WINDOW-1: peak_value <= max(run_peak, mag),
//   peak_valid pulses for 1 cycle, run_peak <= 0, count <= 0.
//   Otherwise run_peak <= max(run_peak, mag).
//   peak_value holds between windows.
//  Clip: set by any S1 sample with raw 000/FFF; cleared by clip_clr.
//   Set and clear in the same cycle: clip ends at 1 (new event wins).
//  No state machine beyond the FIFO pointers and counters; all outputs are registered.
// STRUCTURE
//  mic3_pkg: MIC3_SAMPLE_W=12, MIC3_MIDSCALE=12'd2048, MIC3_PCM_W=16,
//   function mic3_to_signed(raw), function mic3_mag(s).
//  Sub-module mic3_sample_fifo: generic sync FIFO (DATA_W, DEPTH), write/read/full/empty,
//   registered head output, same-cycle push+pop when full. Peak, clip and drop logic are
//   in the top level.
// TESTING
//  1 Reset, then raw=12'h800 strobe with ready=1 -> pcm_valid 2 edges later, pcm_data=16'h0000.
//  2 raw=FFF then 000 then 7FF -> pcm_data 7FF0, 8000, FFF0; clip=1; clip_clr with no clip
//    sample -> clip=0; clip_clr together with raw=000 -> clip stays 1.
//  3 ready=0, 10 back-to-back strobes, FIFO_DEPTH=8 -> 8 stored; drop_count=2 (1 in flight in
//    S1 counts once it is written, or is dropped if full); then ready=1 -> 8 entries in order.
//    Also force 300 drops -> drop_count holds at 255.
//  4 Full FIFO with pcm_ready=1 and a new strobe in the same cycle -> no drop; order preserved.
//  5 WINDOW=4: samples 800,900,000,850 -> peak_valid 1 cycle, peak_value=2048.
//    Next window 800,810,7F0,800 -> peak_value=16.
//  6 Assert sysrst_n low mid-burst with the FIFO half full and the window half done ->
//    outputs 0 immediately. After release the first window needs WINDOW full samples.

Source files
------------

// File: rtl/mic3_pkg.sv
// ============================================================================
// mic3_pkg : shared widths and sample-format helpers for the PmodMIC3 path
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mic3_pkg;

  localparam int          MIC3_SAMPLE_W = 12;
  localparam logic [11:0] MIC3_MIDSCALE = 12'd2048;
  localparam int          MIC3_PCM_W    = 16;

  // Offset-binary to two's complement: subtracting midscale only flips the MSB.
  function automatic logic [MIC3_SAMPLE_W-1:0] mic3_to_signed(
    input logic [MIC3_SAMPLE_W-1:0] raw
  );
    return raw ^ MIC3_MIDSCALE;
  endfunction

  function automatic logic [MIC3_SAMPLE_W-1:0] mic3_mag(
    input logic [MIC3_SAMPLE_W-1:0] s
  );
    return s[MIC3_SAMPLE_W-1] ? (~s + 1'b1) : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mic3_sample_fifo.sv
// ============================================================================
// mic3_sample_fifo : synchronous FIFO with registered head and full-bypass pop
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module mic3_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              valid_q;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = valid_q & rd_en_i;
    do_push  = wr_en_i & ((count_q != FULL_CNT) | do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    // When the only remaining entry is the one being written, bypass it to the head.
    head_d   = (count_q == (PTR_W+1)'(do_pop)) ? wr_data_i : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      if ((!valid_q || do_pop) && (count_d != '0)) head_q <= head_d;
    end
  end

  assign rd_data_o  = head_q;
  assign rd_valid_o = valid_q;
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = ~valid_q;

endmodule

`default_nettype wire

// File: rtl/mic3_sample_conditioner.sv
// ============================================================================
// mic3_sample_conditioner : offset-binary to PCM, FIFO buffering, peak and clip
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module mic3_sample_conditioner
  import mic3_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int WINDOW     = 1024
) (
  input  logic                     sysclk,
  input  logic                     sysrst_n,
  input  logic                     sample_valid,
  input  logic [MIC3_SAMPLE_W-1:0] sample_raw,
  output logic                     pcm_valid,
  input  logic                     pcm_ready,
  output logic [MIC3_PCM_W-1:0]    pcm_data,
  output logic [7:0]               drop_count,
  output logic                     peak_valid,
  output logic [MIC3_SAMPLE_W-1:0] peak_value,
  output logic                     clip,
  input  logic                     clip_clr
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic                     s1_valid_q;
  logic [MIC3_SAMPLE_W-1:0] s1_s_q;
  logic [MIC3_SAMPLE_W-1:0] s1_mag, peak_max;
  logic [MIC3_SAMPLE_W-1:0] run_peak_q, peak_value_q;
  logic [WIN_W-1:0]         win_cnt_q;
  logic                     peak_valid_q, clip_q, clip_hit;
  logic [7:0]               drop_count_q;
  logic                     fifo_full, fifo_empty, drop;
  logic [MIC3_PCM_W-1:0]    pcm_wr;

  always_comb begin
    s1_mag   = mic3_mag(s1_s_q);
    peak_max = (s1_mag > run_peak_q) ? s1_mag : run_peak_q;
    // Raw 000 / FFF map to signed 800 / 7FF after the MSB flip.
    clip_hit = s1_valid_q & ((s1_s_q == 12'h800) | (s1_s_q == 12'h7FF));
    drop     = s1_valid_q & fifo_full & ~(~fifo_empty & pcm_ready);
    pcm_wr   = {s1_s_q, {(MIC3_PCM_W-MIC3_SAMPLE_W){1'b0}}};
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      s1_valid_q   <= 1'b0;
      s1_s_q       <= '0;
      run_peak_q   <= '0;
      peak_value_q <= '0;
      win_cnt_q    <= '0;
      peak_valid_q <= 1'b0;
      clip_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      s1_valid_q   <= sample_valid;
      if (sample_valid) s1_s_q <= mic3_to_signed(sample_raw);
      peak_valid_q <= 1'b0;
      if (s1_valid_q) begin
        if (win_cnt_q == WIN_LAST) begin
          peak_value_q <= peak_max;
          peak_valid_q <= 1'b1;
          run_peak_q   <= '0;
          win_cnt_q    <= '0;
        end else begin
          run_peak_q   <= peak_max;
          win_cnt_q    <= win_cnt_q + 1'b1;
        end
      end
      if (clip_hit)      clip_q <= 1'b1;
      else if (clip_clr) clip_q <= 1'b0;
      if (drop && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;
    end
  end

  mic3_sample_fifo #(
    .DATA_W (MIC3_PCM_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (sysclk),
    .rst_ni     (sysrst_n),
    .wr_en_i    (s1_valid_q),
    .wr_data_i  (pcm_wr),
    .rd_en_i    (pcm_ready),
    .rd_data_o  (pcm_data),
    .rd_valid_o (pcm_valid),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign drop_count = drop_count_q;
  assign peak_valid = peak_valid_q;
  assign peak_value = peak_value_q;
  assign clip       = clip_q;

endmodule

`default_nettype wire
